// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - IFU/LSU arbiter in front of a single-outstanding memory port
//
// Purpose: grants one of two requesters (instruction fetch, load/store) access
// to a memory port. One transaction is in flight at a time. IDLE accepts a
// request, REQ presents it to memory until mem_req_ready, and RESP waits for
// mem_resp_valid. The response is registered and pulsed to the owner one cycle
// later.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   ifu_req_*            fetch request (read only), ready pulses on accept
//   ifu_resp_*           fetch response, one-cycle valid pulse
//   lsu_req_*            load/store request with we/wdata/mask
//   lsu_resp_*           load/store response, one-cycle valid pulse
//   mem_req_*            request to memory, held stable until mem_req_ready
//   mem_resp_*           response from memory, honoured only while waiting
// Config: define ARB_RR_EN for alternating arbitration on conflicts.
//         The default build gives the LSU fixed priority.
module mem_arbiter #(
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ifu_req_valid,
  input  logic [ADDR_W-1:0] ifu_req_addr,
  output logic              ifu_req_ready,
  output logic              ifu_resp_valid,
  output logic [63:0]       ifu_resp_data,
  input  logic              lsu_req_valid,
  input  logic              lsu_req_we,
  input  logic [ADDR_W-1:0] lsu_req_addr,
  input  logic [63:0]       lsu_req_wdata,
  input  logic [7:0]        lsu_req_mask,
  output logic              lsu_req_ready,
  output logic              lsu_resp_valid,
  output logic [63:0]       lsu_resp_data,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [63:0]       mem_req_wdata,
  output logic [7:0]        mem_req_mask,
  input  logic              mem_resp_valid,
  input  logic [63:0]       mem_resp_data
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;   // 1 = LSU owns the transaction
  logic              last_q, last_d;     // 1 = LSU won the last accept
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [63:0]       wdata_q, wdata_d;
  logic [7:0]        mask_q, mask_d;
  logic [63:0]       rdata_q, rdata_d;
  logic              ifu_rv_q, ifu_rv_d;
  logic              lsu_rv_q, lsu_rv_d;
  logic              grant_lsu;
  logic              in_req;

  // A lone valid request always wins. On a conflict, the policy decides.
  always_comb begin
`ifdef ARB_RR_EN
    grant_lsu = lsu_req_valid && (!ifu_req_valid || !last_q);
`else
    grant_lsu = lsu_req_valid;
`endif
  end

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_d        = last_q;
    we_d          = we_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    mask_d        = mask_q;
    rdata_d       = rdata_q;
    ifu_rv_d      = 1'b0;
    lsu_rv_d      = 1'b0;
    ifu_req_ready = 1'b0;
    lsu_req_ready = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Readies are suppressed under reset so nothing is handed off.
        if (!rst && (ifu_req_valid || lsu_req_valid)) begin
          ifu_req_ready = !grant_lsu;
          lsu_req_ready = grant_lsu;
          owner_d       = grant_lsu;
          last_d        = grant_lsu;
          state_d       = S_REQ;
          if (grant_lsu) begin
            we_d    = lsu_req_we;
            addr_d  = lsu_req_addr;
            wdata_d = lsu_req_wdata;
            mask_d  = lsu_req_mask;
          end else begin
            we_d    = 1'b0;
            addr_d  = ifu_req_addr;
            wdata_d = '0;
            mask_d  = 8'hff;
          end
        end
      end
      S_REQ: begin
        if (mem_req_ready) state_d = S_RESP;
      end
      S_RESP: begin
        if (mem_resp_valid) begin
          rdata_d  = mem_resp_data;
          ifu_rv_d = !owner_q;
          lsu_rv_d = owner_q;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      owner_q  <= 1'b0;
      last_q   <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      mask_q   <= '0;
      rdata_q  <= '0;
      ifu_rv_q <= 1'b0;
      lsu_rv_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      mask_q   <= mask_d;
      rdata_q  <= rdata_d;
      ifu_rv_q <= ifu_rv_d;
      lsu_rv_q <= lsu_rv_d;
    end
  end

  // Outputs are forced low while rst is high, even before the reset edge.
  assign in_req         = (state_q == S_REQ) && !rst;
  assign mem_req_valid  = in_req;
  assign mem_req_we     = in_req ? we_q : 1'b0;
  assign mem_req_addr   = in_req ? addr_q : '0;
  assign mem_req_wdata  = in_req ? wdata_q : '0;
  assign mem_req_mask   = in_req ? mask_q : '0;
  assign ifu_resp_valid = ifu_rv_q && !rst;
  assign lsu_resp_valid = lsu_rv_q && !rst;
  assign ifu_resp_data  = rst ? '0 : rdata_q;
  assign lsu_resp_data  = rst ? '0 : rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized and directed bench for mem_arbiter
module tb_mem_arbiter;
  localparam int ADDR_W = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic              ifu_req_valid, ifu_req_ready, ifu_resp_valid;
  logic [ADDR_W-1:0] ifu_req_addr;
  logic [63:0]       ifu_resp_data;
  logic              lsu_req_valid, lsu_req_we, lsu_req_ready, lsu_resp_valid;
  logic [ADDR_W-1:0] lsu_req_addr;
  logic [63:0]       lsu_req_wdata, lsu_resp_data;
  logic [7:0]        lsu_req_mask;
  logic              mem_req_valid, mem_req_ready, mem_req_we, mem_resp_valid;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [63:0]       mem_req_wdata, mem_resp_data;
  logic [7:0]        mem_req_mask;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_addr(ifu_req_addr),
    .ifu_req_ready(ifu_req_ready), .ifu_resp_valid(ifu_resp_valid),
    .ifu_resp_data(ifu_resp_data),
    .lsu_req_valid(lsu_req_valid), .lsu_req_we(lsu_req_we),
    .lsu_req_addr(lsu_req_addr), .lsu_req_wdata(lsu_req_wdata),
    .lsu_req_mask(lsu_req_mask), .lsu_req_ready(lsu_req_ready),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_data(lsu_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_mask(mem_req_mask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Transaction-level reference: one outstanding transaction, its memory
  // handshake, and the response due to its owner on the following cycle.
  typedef struct {
    logic        lsu;
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  mask;
  } txn_t;

  txn_t        cur;
  bit          pending, mem_taken, resp_due, resp_owner_lsu, last_lsu;
  int          resp_wait;
  logic [63:0] resp_data_exp;
  bit          ifu_hold, lsu_hold;
  bit          grant_q[$];

  // Stimulus knobs
  int          p_ifu, p_lsu, fixed_wait, stall_cnt;
  bit          mem_fast, rst_rand, force_spur, force_rdata_en;
  logic [63:0] force_rdata;

  // Observations
  int cyc, acc_cyc, resp_cyc, ifu_pulses, lsu_pulses, mem_v_cycles;

  task automatic cycle_step(input bit do_rst);
    bit r, was_pending, in_resp, send_resp, exp_mem_v, win_lsu, pol_lsu;
    @(posedge clk);
    #1;
    cyc++;
    r           = do_rst || (rst_rand && ($urandom_range(0, 63) == 0));
    was_pending = pending;
    in_resp     = pending && mem_taken;
    send_resp   = in_resp && (resp_wait == 0);
    exp_mem_v   = pending && !mem_taken;
    rst         = r;

    if (!ifu_hold && ($urandom_range(0, 99) < p_ifu)) begin
      ifu_hold     = 1'b1;
      ifu_req_addr = {$urandom, $urandom};
    end
    if (!lsu_hold && ($urandom_range(0, 99) < p_lsu)) begin
      lsu_hold      = 1'b1;
      lsu_req_we    = 1'($urandom_range(0, 1));
      lsu_req_addr  = {$urandom, $urandom};
      lsu_req_wdata = {$urandom, $urandom};
      lsu_req_mask  = 8'($urandom);
    end
    ifu_req_valid = ifu_hold;
    lsu_req_valid = lsu_hold;

    if (exp_mem_v && stall_cnt > 0) begin
      mem_req_ready = 1'b0;
      stall_cnt--;
    end else begin
      mem_req_ready = mem_fast ? 1'b1 : ($urandom_range(0, 2) == 0);
    end
    if (in_resp) mem_resp_valid = send_resp;
    else         mem_resp_valid = force_spur || ($urandom_range(0, 3) == 0);
    mem_resp_data = force_rdata_en ? force_rdata : {$urandom, $urandom};
    #1;

`ifdef ARB_RR_EN
    pol_lsu = !last_lsu;
`else
    pol_lsu = 1'b1;
`endif
    win_lsu = lsu_hold && (!ifu_hold || pol_lsu);

    if (r) begin
      check_eq("rst_ifu_ready", ifu_req_ready, 0);
      check_eq("rst_lsu_ready", lsu_req_ready, 0);
      check_eq("rst_mem_valid", mem_req_valid, 0);
      check_eq("rst_mem_mask", mem_req_mask, 0);
      check_eq("rst_ifu_resp", ifu_resp_valid, 0);
      check_eq("rst_lsu_resp", lsu_resp_valid, 0);
    end else begin
      check_eq("ifu_resp_valid", ifu_resp_valid, resp_due && !resp_owner_lsu);
      check_eq("lsu_resp_valid", lsu_resp_valid, resp_due && resp_owner_lsu);
      if (resp_due && resp_owner_lsu)  check_eq("lsu_resp_data", lsu_resp_data, resp_data_exp);
      if (resp_due && !resp_owner_lsu) check_eq("ifu_resp_data", ifu_resp_data, resp_data_exp);
      check_eq("mem_req_valid", mem_req_valid, exp_mem_v);
      if (exp_mem_v) begin
        check_eq("mem_req_we", mem_req_we, cur.we);
        check_eq("mem_req_addr", mem_req_addr, cur.addr);
        check_eq("mem_req_wdata", mem_req_wdata, cur.wdata);
        check_eq("mem_req_mask", mem_req_mask, cur.mask);
      end
      check_eq("ifu_req_ready", ifu_req_ready, !was_pending && ifu_hold && !win_lsu);
      check_eq("lsu_req_ready", lsu_req_ready, !was_pending && win_lsu);
      if (ifu_resp_valid) begin ifu_pulses++; resp_cyc = cyc; end
      if (lsu_resp_valid) begin lsu_pulses++; resp_cyc = cyc; end
      if (mem_req_valid) mem_v_cycles++;
    end

    if (r) begin
      pending   = 1'b0;
      mem_taken = 1'b0;
      resp_due  = 1'b0;
      last_lsu  = 1'b0;
    end else begin
      resp_due = send_resp;
      if (send_resp) begin
        resp_data_exp  = mem_resp_data;
        resp_owner_lsu = cur.lsu;
        pending        = 1'b0;
        mem_taken      = 1'b0;
      end else if (in_resp) begin
        resp_wait--;
      end
      if (exp_mem_v && mem_req_ready) begin
        mem_taken = 1'b1;
        resp_wait = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 3));
      end
      if (!was_pending && (ifu_hold || lsu_hold)) begin
        cur.lsu   = win_lsu;
        cur.we    = win_lsu ? lsu_req_we : 1'b0;
        cur.addr  = win_lsu ? lsu_req_addr : ifu_req_addr;
        cur.wdata = win_lsu ? lsu_req_wdata : 64'd0;
        cur.mask  = win_lsu ? lsu_req_mask : 8'hff;
        pending   = 1'b1;
        mem_taken = 1'b0;
        last_lsu  = win_lsu;
        acc_cyc   = cyc;
        grant_q.push_back(win_lsu);
        if (win_lsu) lsu_hold = 1'b0;
        else         ifu_hold = 1'b0;
      end
    end
  endtask

  initial begin
    int base_i, base_l, n;
    rst = 1'b1;
    ifu_req_valid = 0; ifu_req_addr = '0;
    lsu_req_valid = 0; lsu_req_we = 0; lsu_req_addr = '0; lsu_req_wdata = '0; lsu_req_mask = '0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = '0;
    p_ifu = 0; p_lsu = 0; fixed_wait = 0; stall_cnt = 0;
    mem_fast = 1; rst_rand = 0; force_spur = 0; force_rdata_en = 0; force_rdata = '0;
    cyc = 0; ifu_pulses = 0; lsu_pulses = 0; mem_v_cycles = 0; acc_cyc = 0; resp_cyc = 0;
    repeat (3) cycle_step(1);

    // IFU-only read, memory ready at once, response two cycles after handshake
    fixed_wait = 1; force_rdata_en = 1; force_rdata = 64'h1234;
    ifu_hold = 1; ifu_req_addr = 64'h8000_0000;
    base_i = ifu_pulses; base_l = lsu_pulses;
    repeat (8) cycle_step(0);
    check_eq("read_latency", 64'(resp_cyc - acc_cyc), 64'd4);
    check_eq("read_ifu_pulses", 64'(ifu_pulses - base_i), 64'd1);
    check_eq("read_lsu_pulses", 64'(lsu_pulses - base_l), 64'd0);
    force_rdata_en = 0;

    // Store held off by three cycles of backpressure
    fixed_wait = 0; stall_cnt = 3; mem_v_cycles = 0;
    lsu_hold = 1; lsu_req_we = 1; lsu_req_addr = 64'h8000_1000;
    lsu_req_mask = 8'h0f; lsu_req_wdata = 64'hdead_beef;
    base_i = ifu_pulses; base_l = lsu_pulses;
    repeat (10) cycle_step(0);
    check_eq("store_mem_cycles", 64'(mem_v_cycles), 64'd4);
    check_eq("store_lsu_pulses", 64'(lsu_pulses - base_l), 64'd1);
    check_eq("store_ifu_pulses", 64'(ifu_pulses - base_i), 64'd0);

    // Four back-to-back conflicts from reset
    repeat (2) cycle_step(1);
    grant_q.delete();
    p_ifu = 100; p_lsu = 100; n = 0;
    while (grant_q.size() < 4 && n < 40) begin cycle_step(0); n++; end
    p_ifu = 0; p_lsu = 0;
    check_eq("conflict_grants", 64'(grant_q.size() >= 4), 64'd1);
    for (int i = 0; i < 4 && i < grant_q.size(); i++) begin
`ifdef ARB_RR_EN
      check_eq($sformatf("conflict_grant%0d", i), 64'(grant_q[i]), 64'((i % 2) == 0));
`else
      check_eq($sformatf("conflict_grant%0d", i), 64'(grant_q[i]), 64'd1);
`endif
    end
    repeat (12) cycle_step(0);
    ifu_hold = 0; lsu_hold = 0;
    repeat (6) cycle_step(0);

    // Reset while waiting for the response, then a late response
    repeat (2) cycle_step(1);
    fixed_wait = 3; ifu_hold = 1; ifu_req_addr = 64'h8000_2000; n = 0;
    while (!(pending && mem_taken) && n < 20) begin cycle_step(0); n++; end
    check_eq("reached_resp_wait", 64'(pending && mem_taken), 64'd1);
    base_i = ifu_pulses; base_l = lsu_pulses;
    cycle_step(1);
    force_spur = 1;
    cycle_step(0);
    force_spur = 0;
    repeat (3) cycle_step(0);
    check_eq("late_resp_ifu", 64'(ifu_pulses - base_i), 64'd0);
    check_eq("late_resp_lsu", 64'(lsu_pulses - base_l), 64'd0);
    fixed_wait = 0; ifu_hold = 1; ifu_req_addr = 64'h8000_3000;
    repeat (6) cycle_step(0);
    check_eq("after_rst_ifu", 64'(ifu_pulses - base_i), 64'd1);

    // Randomized traffic with random resets
    p_ifu = 35; p_lsu = 35; mem_fast = 0; fixed_wait = -1; rst_rand = 1;
    repeat (3000) cycle_step(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 64, meaning the width of all address ports.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-004 SHALL have the IFU ports: ifu_req_valid in 1; ifu_req_addr in ADDR_W; ifu_req_ready out 1; ifu_resp_valid out 1; ifu_resp_data out 64.
REQ-005 SHALL have the LSU ports: lsu_req_valid in 1; lsu_req_we in 1; lsu_req_addr in ADDR_W; lsu_req_wdata in 64; lsu_req_mask in 8; lsu_req_ready out 1; lsu_resp_valid out 1; lsu_resp_data out 64.
REQ-006 SHALL have the memory-side ports: mem_req_valid out 1; mem_req_ready in 1; mem_req_we out 1; mem_req_addr out ADDR_W; mem_req_wdata out 64; mem_req_mask out 8; mem_resp_valid in 1; mem_resp_data in 64.

Function
REQ-007 SHALL implement an FSM with states IDLE, REQ and RESP, and handle one outstanding transaction at a time.
REQ-008 In IDLE, when either req_valid is high, the block SHALL select a winner, pulse that requester's req_ready for exactly that cycle, latch the winner's fields and owner, and move to REQ.
REQ-009 In IDLE with no valid request, the FSM SHALL stay in IDLE and both req_ready outputs SHALL be 0.
REQ-010 In REQ, mem_req_valid SHALL be 1 with the latched fields; the FSM SHALL move to RESP in the cycle after mem_req_ready=1 and otherwise hold REQ with the fields stable.
REQ-011 Latched fields for an IFU winner SHALL be: we=0, mask=8'hff, wdata=0.
REQ-012 In RESP, on mem_resp_valid=1 the block SHALL register mem_resp_data, pulse the owner's resp_valid for 1 cycle in the next cycle with that data, and return to IDLE.
REQ-013 Store transactions SHALL also complete through RESP; lsu_resp_valid pulses and lsu_resp_data carries the memory's returned data.
REQ-014 mem_resp_valid SHALL be ignored in IDLE and REQ.
REQ-015 Minimum latency SHALL be: accept at cycle 0, mem_req_valid at cycle 1, resp_valid at cycle (resp cycle + 1).
REQ-016 A new request SHALL be acceptable in the same cycle the previous resp_valid pulses, because the FSM is in IDLE by then.
REQ-017 The non-owner's resp_valid SHALL never assert, and both resp_valid outputs SHALL never be high simultaneously.
REQ-018 A requester SHALL hold its valid and fields until its req_ready is seen; the block samples them only in the accept cycle.

Reset
REQ-019 While rst=1, the FSM SHALL go to IDLE; all outputs SHALL be 0 except mem_req_mask=0; the owner and last-grant registers SHALL clear to IFU.
REQ-020 Assertion of rst in REQ or RESP SHALL drop the in-flight transaction without any resp_valid pulse; a late mem_resp_valid after reset SHALL be ignored per REQ-014.

Configuration
REQ-021 Macro ARB_RR_EN SHALL select the arbitration policy.
REQ-022 Without ARB_RR_EN, simultaneous valid requests SHALL be resolved with fixed LSU priority.
REQ-023 With ARB_RR_EN, simultaneous valid requests SHALL be granted to the requester not granted last; a last-grant register SHALL be updated on every accept; a single valid request SHALL always be granted immediately.

Verification
REQ-024 IFU-only read: ifu addr 0x80000000 with mem_req_ready=1 immediately and resp 0x1234 two cycles later -> ifu_req_ready at cycle 0, mem_req_valid at cycle 1, ifu_resp_valid with 0x1234 at cycle 4, lsu_resp_valid=0 throughout.
REQ-025 Store with backpressure: lsu we=1, addr 0x80001000, mask 8'h0f, wdata 0xdeadbeef, mem_req_ready low for 3 cycles -> mem fields stable for 4 cycles, exactly one lsu_resp_valid pulse.
REQ-026 Simultaneous requests, 4 back-to-back conflicts: without ARB_RR_EN -> grants L,L,L,L while LSU keeps requesting; with ARB_RR_EN -> grants L,I,L,I.
REQ-027 Spurious response: mem_resp_valid=1 while in IDLE or REQ -> no resp_valid pulse and no state change.
REQ-028 Reset mid-operation: rst=1 for 1 cycle while in RESP, then mem_resp_valid=1 -> no resp_valid, FSM in IDLE, next IFU request served normally.
